// File: rtl/paralelo_serial_param_pkg.sv
// Shared definitions for the parallel-to-serial converter: FSM states, default idle word, frame length.
// Define PS_PARITY_EN to append one even-parity bit to every frame.
package paralelo_serial_param_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_DATA = 2'd2
    } ps_state_t;

    // K28.5-style comma keeps the lane toggling when no data is queued
    localparam logic [7:0] DEFAULT_IDLE_WORD = 8'hBC;

`ifdef PS_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/paralelo_serial_param_fifo.sv
// ps_fifo: small synchronous FIFO with push/pop/full/empty/level, pointers wrapping modulo DEPTH.
// Push while full and pop while empty are ignored.
module ps_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                             clk_32f,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic [WIDTH-1:0]                 wr_data,
    output logic [WIDTH-1:0]                 rd_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_32f) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                level <= level + LW'(1);
            else if (do_pop && !do_push)
                level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/paralelo_serial_param.sv
// Parametrised parallel-to-serial converter: FIFO-buffered words shifted out one bit per clk_32f,
// idle word inserted when the FIFO is empty. Optional parity bit when PS_PARITY_EN is defined.
module paralelo_serial_param
    import paralelo_serial_param_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(DEFAULT_IDLE_WORD)
) (
    input  logic                         clk_32f,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    input  logic                         msb_first,
    output logic                         data_out,
    output logic                         frame_start,
    output logic                         data_active,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int FLEN = frame_len(WIDTH);
    localparam int CW   = $clog2(FLEN+1);
    localparam int LW   = $clog2(DEPTH+1);

    ps_state_t        state;
    ps_state_t        next_state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             msb_reg;
    logic             frame_load;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic [WIDTH-1:0] load_word;
    logic [LW-1:0]    level_next;
`ifdef PS_PARITY_EN
    logic             parity_reg;
`endif

    ps_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_32f (clk_32f),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (data_in),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign fifo_push  = valid_in && ready_out && !fifo_full;
    assign load_word  = fifo_pop ? fifo_rd_data : IDLE_WORD;
    assign level_next = fifo_level + LW'(fifo_push) - LW'(fifo_pop);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset)
            state <= ST_INIT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (frame_load)
            next_state = fifo_empty ? ST_IDLE : ST_DATA;
    end

    // The first edge out of reset behaves like a frame boundary
    always_comb begin
        frame_load  = (state == ST_INIT) || (bit_cnt == CW'(FLEN-1));
        fifo_pop    = frame_load && !fifo_empty;
        data_active = (state == ST_DATA);
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            ready_out   <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            msb_reg     <= 1'b0;
            data_out    <= 1'b0;
            frame_start <= 1'b0;
`ifdef PS_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            ready_out <= (level_next < LW'(DEPTH));
            if (frame_load) begin
                bit_cnt     <= '0;
                frame_start <= 1'b1;
                msb_reg     <= msb_first;
                data_out    <= msb_first ? load_word[WIDTH-1] : load_word[0];
                shreg       <= msb_first ? (load_word << 1) : (load_word >> 1);
`ifdef PS_PARITY_EN
                parity_reg  <= ^load_word;
`endif
            end else begin
                bit_cnt     <= bit_cnt + CW'(1);
                frame_start <= 1'b0;
`ifdef PS_PARITY_EN
                if (bit_cnt == CW'(WIDTH-1)) begin
                    data_out <= parity_reg;
                end else begin
                    data_out <= msb_reg ? shreg[WIDTH-1] : shreg[0];
                    shreg    <= msb_reg ? (shreg << 1) : (shreg >> 1);
                end
`else
                data_out <= msb_reg ? shreg[WIDTH-1] : shreg[0];
                shreg    <= msb_reg ? (shreg << 1) : (shreg >> 1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Self-checking bench for paralelo_serial_param: per-cycle comparison against a frame-level model,
// plus literal frame checks. Honours PS_PARITY_EN when defined.
module tb_paralelo_serial_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef PS_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic              clk_32f = 1'b0;
    logic              reset = 1'b0;
    logic [WIDTH-1:0]  data_in = '0;
    logic              valid_in = 1'b0;
    logic              msb_first = 1'b1;
    logic              ready_out;
    logic              data_out;
    logic              frame_start;
    logic              data_active;
    logic [2:0]        fifo_level;

    int tests = 0;
    int failures = 0;

    paralelo_serial_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_WORD(8'hBC)) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .msb_first   (msb_first),
        .data_out    (data_out),
        .frame_start (frame_start),
        .data_active (data_active),
        .fifo_level  (fifo_level)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: queue of accepted words, current frame word and bit index
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] cur_word = '0;
    logic             cur_data = 1'b0;
    logic             cur_msb = 1'b0;
    int               m_b = 0;
    int               k = 0;
    logic             m_valid = 1'b0;
    logic             m_ready = 1'b0;

    always @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_valid = 1'b0;
            m_ready = 1'b0;
            k = 0;
            m_b = 0;
        end else begin
            logic pushed;
            pushed = valid_in && m_ready;
            if (k % FLEN == 0) begin
                if (q.size() > 0) begin
                    cur_word = q.pop_front();
                    cur_data = 1'b1;
                end else begin
                    cur_word = 8'hBC;
                    cur_data = 1'b0;
                end
                cur_msb = msb_first;
                m_b = 0;
            end else begin
                m_b++;
            end
            if (pushed)
                q.push_back(data_in);
            m_ready = (q.size() < DEPTH);
            m_valid = 1'b1;
            k++;
        end
    end

    always @(negedge clk_32f) begin
        logic exp_bit, exp_fs, exp_act;
        exp_bit = 1'b0;
        exp_fs  = 1'b0;
        exp_act = 1'b0;
        if (m_valid) begin
            if (m_b >= WIDTH)
                exp_bit = ^cur_word;
            else
                exp_bit = cur_msb ? cur_word[WIDTH-1-m_b] : cur_word[m_b];
            exp_fs  = (m_b == 0);
            exp_act = cur_data;
        end
        checkOutput("data_out", data_out, exp_bit);
        checkOutput("frame_start", frame_start, exp_fs);
        checkOutput("data_active", data_active, exp_act);
        checkOutput("ready_out", ready_out, m_ready);
        checkOutput("fifo_level", fifo_level, q.size());
    end

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic m);
        @(negedge clk_32f);
        valid_in  = v;
        data_in   = d;
        msb_first = m;
    endtask

    // Serial bits in transmission order, first bit ends up most significant
    task automatic captureFrame(input logic need_data, output logic [8:0] bits);
        int n;
        n = 0;
        bits = '0;
        @(negedge clk_32f);
        while (!(frame_start && (!need_data || data_active)) && n < 64) begin
            @(negedge clk_32f);
            n++;
        end
        if (n >= 64) begin
            checkOutput("frame_timeout", 32'd1, 32'd0);
        end else begin
            for (int i = 0; i < FLEN; i++) begin
                bits = {bits[7:0], data_out};
                if (i < FLEN-1)
                    @(negedge clk_32f);
            end
        end
    endtask

    function automatic logic [8:0] frameOf(input logic [7:0] bits8, input logic par);
`ifdef PS_PARITY_EN
        return {bits8, par};
`else
        return {1'b0, bits8};
`endif
    endfunction

    initial begin
        logic [8:0] cap;
        logic       saw_low;
        int         n;

        $display("[TB] start, FLEN=%0d", FLEN);
        repeat (3) @(negedge clk_32f);
        checkOutput("rst_data_out", data_out, 0);
        checkOutput("rst_ready_out", ready_out, 0);
        checkOutput("rst_fifo_level", fifo_level, 0);
        checkOutput("rst_frame_start", frame_start, 0);
        reset = 1'b1;

        captureFrame(1'b0, cap);
        checkOutput("idle_frame_bc", cap, frameOf(8'b10111100, 1'b1));
        checkOutput("idle_inactive", data_active, 0);
        captureFrame(1'b0, cap);
        checkOutput("idle_frame_bc_2", cap, frameOf(8'b10111100, 1'b1));

        applyStimulus(1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        captureFrame(1'b1, cap);
        checkOutput("frame_ff_msb", cap, frameOf(8'b11111111, 1'b0));
        captureFrame(1'b0, cap);
        checkOutput("frame_ee_msb", cap, frameOf(8'b11101110, 1'b0));
        captureFrame(1'b0, cap);
        checkOutput("frame_after_is_idle", cap, frameOf(8'b10111100, 1'b1));

        applyStimulus(1'b1, 8'hEE, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        captureFrame(1'b1, cap);
        checkOutput("frame_ee_lsb", cap, frameOf(8'b01110111, 1'b0));

        applyStimulus(1'b1, 8'hAA, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        captureFrame(1'b1, cap);
        checkOutput("frame_aa_msb", cap, frameOf(8'b10101010, 1'b0));

        saw_low = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b1);
            if (!ready_out) saw_low = 1'b1;
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("ready_low_when_full", saw_low, 1);
        repeat (6 * FLEN) @(negedge clk_32f);

        for (int i = 0; i < 800; i++)
            applyStimulus(($urandom % 3) != 0, 8'($urandom), ($urandom % 8) != 0 ? msb_first : ~msb_first);
        applyStimulus(1'b0, 8'h00, 1'b1);
        repeat (6 * FLEN) @(negedge clk_32f);

        applyStimulus(1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        n = 0;
        while (!(frame_start && data_active) && n < 64) begin
            @(negedge clk_32f);
            n++;
        end
        checkOutput("data_frame_seen", n < 64, 1);
        repeat (3) @(negedge clk_32f);
        checkOutput("bit3_before_reset", data_out, 1);
        checkOutput("level_before_reset", fifo_level, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_data_out", data_out, 0);
        checkOutput("abort_fifo_level", fifo_level, 0);
        checkOutput("abort_ready_out", ready_out, 0);
        checkOutput("abort_data_active", data_active, 0);
        repeat (2) @(negedge clk_32f);
        reset = 1'b1;
        captureFrame(1'b0, cap);
        checkOutput("restart_idle_frame", cap, frameOf(8'b10111100, 1'b1));
        repeat (2 * FLEN) @(negedge clk_32f);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
